// File: rtl/sdrc_access_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------------------------
// sdrc_access_arbiter: shares the SDRAM controller command port between video (p0) and SPI (p1).
// Define SDRC_ARB_STARVE_GUARD_EN to bound consecutive p0 grants while p1 waits.  Rev 1.0
// ---------------------------------------------------------------------------------------------
module sdrc_access_arbiter #(
  parameter int ADDR_W     = 21,
  parameter int LEN_W      = 7,
  parameter int P0_MAX_RUN = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              p0_req_i,
  output logic              p0_ack_o,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [LEN_W-1:0]  p0_len_i,
  output logic              p0_rvalid_o,
  output logic              p0_done_o,
  input  logic              p1_req_i,
  output logic              p1_ack_o,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [LEN_W-1:0]  p1_len_i,
  input  logic              p1_we_i,
  input  logic [31:0]       p1_wdata_i,
  input  logic [3:0]        p1_wdqm_i,
  output logic              p1_wnext_o,
  output logic              p1_rvalid_o,
  output logic              p1_done_o,
  output logic [31:0]       rdata_o,
  input  logic              sdrc_init_done_i,
  input  logic              sdrc_busy_n_i,
  input  logic              sdrc_rd_valid_i,
  input  logic              sdrc_wrd_ack_i,
  input  logic [31:0]       sdrc_data_read_i,
  output logic              sdrc_rd_n_o,
  output logic              sdrc_wr_n_o,
  output logic [ADDR_W-1:0] sdrc_addr_o,
  output logic [LEN_W-1:0]  sdrc_len_o,
  output logic [3:0]        sdrc_dqm_o,
  output logic [31:0]       sdrc_data_write_o,
  output logic              sdrc_self_refresh_o,
  output logic              sdrc_power_down_o
);

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_XFER  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [3:0]        dqm_q, dqm_d;
  logic [LEN_W:0]    cnt_q, cnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;

  logic           any_req, grant_p1, force_p1, ack0, ack1;
  logic           rd_beat, wr_beat, last_beat, issue;
  logic [LEN_W:0] cnt_inc, beats;

  assign any_req   = p0_req_i | p1_req_i;
  assign grant_p1  = p1_req_i & (~p0_req_i | force_p1);
  assign ack0      = (state_q == ST_IDLE) & any_req & ~grant_p1;
  assign ack1      = (state_q == ST_IDLE) & grant_p1;
  assign issue     = (state_q == ST_ISSUE) & sdrc_busy_n_i;
  assign rd_beat   = (state_q == ST_XFER) & ~we_q & sdrc_rd_valid_i;
  assign wr_beat   = (state_q == ST_XFER) & we_q & sdrc_wrd_ack_i;
  // Counter is one bit wider than len so a 128-beat burst reaches len+1 without wrapping.
  assign cnt_inc   = cnt_q + (LEN_W+1)'(1);
  assign beats     = {1'b0, len_q} + (LEN_W+1)'(1);
  assign last_beat = (rd_beat | wr_beat) & (cnt_inc == beats);

`ifdef SDRC_ARB_STARVE_GUARD_EN
  localparam int RUN_W = $clog2(P0_MAX_RUN + 1);
  logic [RUN_W-1:0] run_q, run_d;

  assign force_p1 = (run_q >= RUN_W'(P0_MAX_RUN));

  always_comb begin
    run_d = run_q;
    if (!p1_req_i || ack1) begin
      run_d = '0;
    end else if (ack0) begin
      run_d = run_q + RUN_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) run_q <= '0;
    else         run_q <= run_d;
  end
`else
  // Without the guard P0_MAX_RUN has no effect; priority stays strictly fixed.
  assign force_p1 = (P0_MAX_RUN < 0);
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    len_d    = len_q;
    dqm_d    = dqm_q;
    cnt_d    = cnt_q;
    rvalid_d = 2'b00;
    done_d   = 2'b00;
    rdata_d  = rdata_q;
    case (state_q)
      ST_INIT: if (sdrc_init_done_i) state_d = ST_IDLE;
      ST_IDLE: begin
        if (any_req) begin
          owner_d = grant_p1;
          addr_d  = grant_p1 ? p1_addr_i : p0_addr_i;
          len_d   = grant_p1 ? p1_len_i  : p0_len_i;
          we_d    = grant_p1 & p1_we_i;
          dqm_d   = grant_p1 ? p1_wdqm_i : 4'b0000;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
        if (sdrc_busy_n_i) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (rd_beat | wr_beat) cnt_d = cnt_inc;
        if (last_beat) begin
          done_d[owner_q] = 1'b1;
          state_d         = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
    if (rd_beat) begin
      rvalid_d[owner_q] = 1'b1;
      rdata_d           = sdrc_data_read_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_INIT;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      dqm_q    <= 4'b0000;
      cnt_q    <= '0;
      rvalid_q <= 2'b00;
      done_q   <= 2'b00;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      dqm_q    <= dqm_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
    end
  end

  assign p0_ack_o            = ack0;
  assign p1_ack_o            = ack1;
  assign p0_rvalid_o         = rvalid_q[0];
  assign p1_rvalid_o         = rvalid_q[1];
  assign p0_done_o           = done_q[0];
  assign p1_done_o           = done_q[1];
  assign rdata_o             = rdata_q;
  assign p1_wnext_o          = wr_beat & owner_q;
  assign sdrc_rd_n_o         = ~(issue & ~we_q);
  assign sdrc_wr_n_o         = ~(issue & we_q);
  assign sdrc_addr_o         = addr_q;
  assign sdrc_len_o          = len_q;
  assign sdrc_dqm_o          = dqm_q;
  assign sdrc_data_write_o   = (owner_q & we_q & ((state_q == ST_ISSUE) | (state_q == ST_XFER)))
                               ? p1_wdata_i : 32'h0;
  assign sdrc_self_refresh_o = 1'b0;
  assign sdrc_power_down_o   = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_sdrc_access_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------------------------
// tb_sdrc_access_arbiter: directed vector table plus hand sequences for sdrc_access_arbiter.
// ---------------------------------------------------------------------------------------------
module tb_sdrc_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_ack, p0_rvalid, p0_done;
  logic [20:0] p0_addr;
  logic [6:0]  p0_len;
  logic        p1_req, p1_ack, p1_we, p1_wnext, p1_rvalid, p1_done;
  logic [20:0] p1_addr;
  logic [6:0]  p1_len;
  logic [31:0] p1_wdata;
  logic [3:0]  p1_wdqm;
  logic [31:0] rdata;
  logic        init_done, busy_n, rd_valid, wrd_ack;
  logic [31:0] data_read;
  logic        sdrc_rd_n, sdrc_wr_n, self_ref, pwr_dn;
  logic [20:0] sdrc_addr;
  logic [6:0]  sdrc_len;
  logic [3:0]  sdrc_dqm;
  logic [31:0] sdrc_data_write;

  always #5 clk = ~clk;

  sdrc_access_arbiter #(.ADDR_W(21), .LEN_W(7), .P0_MAX_RUN(4)) dut (
    .clock_i(clk), .reset_i(rst),
    .p0_req_i(p0_req), .p0_ack_o(p0_ack), .p0_addr_i(p0_addr), .p0_len_i(p0_len),
    .p0_rvalid_o(p0_rvalid), .p0_done_o(p0_done),
    .p1_req_i(p1_req), .p1_ack_o(p1_ack), .p1_addr_i(p1_addr), .p1_len_i(p1_len),
    .p1_we_i(p1_we), .p1_wdata_i(p1_wdata), .p1_wdqm_i(p1_wdqm), .p1_wnext_o(p1_wnext),
    .p1_rvalid_o(p1_rvalid), .p1_done_o(p1_done), .rdata_o(rdata),
    .sdrc_init_done_i(init_done), .sdrc_busy_n_i(busy_n), .sdrc_rd_valid_i(rd_valid),
    .sdrc_wrd_ack_i(wrd_ack), .sdrc_data_read_i(data_read),
    .sdrc_rd_n_o(sdrc_rd_n), .sdrc_wr_n_o(sdrc_wr_n), .sdrc_addr_o(sdrc_addr),
    .sdrc_len_o(sdrc_len), .sdrc_dqm_o(sdrc_dqm), .sdrc_data_write_o(sdrc_data_write),
    .sdrc_self_refresh_o(self_ref), .sdrc_power_down_o(pwr_dn)
  );

  // Event counters, sampled on the falling edge.
  int m_rd = 0, m_wr = 0, m_rv0 = 0, m_rv1 = 0, m_wn = 0, m_d0 = 0, m_d1 = 0, m_a0 = 0, m_a1 = 0;
  always @(negedge clk) begin
    if (!sdrc_rd_n) m_rd++;
    if (!sdrc_wr_n) m_wr++;
    if (p0_rvalid)  m_rv0++;
    if (p1_rvalid)  m_rv1++;
    if (p1_wnext)   m_wn++;
    if (p0_done)    m_d0++;
    if (p1_done)    m_d1++;
    if (p0_ack)     m_a0++;
    if (p1_ack)     m_a1++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [20:0] addr;
    logic [6:0]  len;
    logic [3:0]  dqm;
    int          busy;
    logic [31:0] base;
    int          exp_beats;
    logic [3:0]  exp_dqm;
  } vec_t;

  vec_t vecs[5];

  // Raise the request for v.port and wait for its ack; returns in the ISSUE cycle.
  task automatic req_and_ack(input vec_t v, input string nm, output bit got);
    bit other = 1'b0;
    got = 1'b0;
    if (v.port) begin
      p1_req = 1'b1; p1_addr = v.addr; p1_len = v.len; p1_we = v.we; p1_wdqm = v.dqm;
    end else begin
      p0_req = 1'b1; p0_addr = v.addr; p0_len = v.len;
    end
    for (int c = 0; c < 10; c++) begin
      #1;
      if ((v.port ? p0_ack : p1_ack) == 1'b1) other = 1'b1;
      if ((v.port ? p1_ack : p0_ack) == 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk({nm, "_ack"}, 64'(got), 64'd1);
    chk({nm, "_wrong_ack"}, 64'(other), 64'd0);
    if (got) step();
    if (v.port) p1_req = 1'b0;
    else        p0_req = 1'b0;
  endtask

  // Drive the ISSUE/XFER phases of an already granted burst; returns in the first IDLE cycle.
  task automatic complete_burst(input vec_t v, input string nm);
    int s_rd, s_wr, s_rv0, s_rv1, s_wn, s_d0, s_d1;
    int i, cyc;
    bit bad, prev_beat, drive;
    logic [31:0] prev_data;
    s_rd = m_rd; s_wr = m_wr; s_rv0 = m_rv0; s_rv1 = m_rv1; s_wn = m_wn; s_d0 = m_d0; s_d1 = m_d1;
    bad = 1'b0;
    busy_n = (v.busy == 0);
    for (int b = 0; b < v.busy; b++) begin
      #1;
      if (!sdrc_rd_n || !sdrc_wr_n) bad = 1'b1;
      step();
    end
    if (v.busy > 0) chk({nm, "_busy_hold"}, 64'(bad), 64'd0);
    busy_n = 1'b1;
    #1;
    chk({nm, "_rd_n"}, 64'(sdrc_rd_n), 64'(v.we));
    chk({nm, "_wr_n"}, 64'(sdrc_wr_n), 64'(!v.we));
    chk({nm, "_addr"}, 64'(sdrc_addr), 64'(v.addr));
    chk({nm, "_len"},  64'(sdrc_len),  64'(v.len));
    chk({nm, "_dqm"},  64'(sdrc_dqm),  64'(v.exp_dqm));
    step();
    i = 0; cyc = 0; prev_beat = 1'b0; prev_data = 32'h0;
    while ((i < v.exp_beats || prev_beat) && cyc < 400) begin
      drive     = (i < v.exp_beats) && (cyc % 3 != 2);
      rd_valid  = drive && !v.we;
      wrd_ack   = drive && v.we;
      data_read = v.base + 32'(i);
      p1_wdata  = v.base + 32'(i);
      #1;
      if (prev_beat && !v.we) begin
        chk({nm, "_rvalid"}, 64'(v.port ? p1_rvalid : p0_rvalid), 64'd1);
        chk({nm, "_rdata"}, 64'(rdata), 64'(prev_data));
      end
      if (drive && v.we) begin
        chk({nm, "_wnext"}, 64'(p1_wnext), 64'd1);
        chk({nm, "_wdata"}, 64'(sdrc_data_write), 64'(v.base + 32'(i)));
      end
      if (prev_beat && i == v.exp_beats)
        chk({nm, "_done"}, 64'(v.port ? p1_done : p0_done), 64'd1);
      prev_beat = drive;
      prev_data = v.base + 32'(i);
      if (drive) i++;
      step();
      cyc++;
    end
    rd_valid = 1'b0; wrd_ack = 1'b0;
    chk({nm, "_beats_sent"}, 64'(i), 64'(v.exp_beats));
    chk({nm, "_rd_strobes"}, 64'(m_rd - s_rd), v.we ? 64'd0 : 64'd1);
    chk({nm, "_wr_strobes"}, 64'(m_wr - s_wr), v.we ? 64'd1 : 64'd0);
    chk({nm, "_rv_owner"}, 64'(v.port ? m_rv1 - s_rv1 : m_rv0 - s_rv0), v.we ? 64'd0 : 64'(v.exp_beats));
    chk({nm, "_rv_other"}, 64'(v.port ? m_rv0 - s_rv0 : m_rv1 - s_rv1), 64'd0);
    chk({nm, "_wnext_cnt"}, 64'(m_wn - s_wn), v.we ? 64'(v.exp_beats) : 64'd0);
    chk({nm, "_done_owner"}, 64'(v.port ? m_d1 - s_d1 : m_d0 - s_d0), 64'd1);
    chk({nm, "_done_other"}, 64'(v.port ? m_d0 - s_d0 : m_d1 - s_d1), 64'd0);
  endtask

  task automatic run_burst(input vec_t v, input string nm);
    bit got;
    req_and_ack(v, nm, got);
    if (got) complete_burst(v, nm);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt, vg;
    bit got, bad, which;
    int s0, s1, sd;

    vecs[0] = '{port:1'b0, we:1'b0, addr:21'h000100, len:7'd7,   dqm:4'hF,    busy:0,
                base:32'hC0DE_0000, exp_beats:8,   exp_dqm:4'b0000};
    vecs[1] = '{port:1'b1, we:1'b1, addr:21'h1ABCDE, len:7'd3,   dqm:4'b0011, busy:0,
                base:32'hA5A5_0000, exp_beats:4,   exp_dqm:4'b0011};
    vecs[2] = '{port:1'b1, we:1'b0, addr:21'h000055, len:7'd0,   dqm:4'b0000, busy:2,
                base:32'h1234_5600, exp_beats:1,   exp_dqm:4'b0000};
    vecs[3] = '{port:1'b0, we:1'b0, addr:21'h1FFFFF, len:7'd127, dqm:4'h0,    busy:0,
                base:32'h8000_0000, exp_beats:128, exp_dqm:4'b0000};
    vecs[4] = '{port:1'b1, we:1'b1, addr:21'h0F0F0F, len:7'd0,   dqm:4'b1100, busy:20,
                base:32'h5A5A_FF00, exp_beats:1,   exp_dqm:4'b1100};

    rst = 1'b1; init_done = 1'b0; busy_n = 1'b1; rd_valid = 1'b0; wrd_ack = 1'b0;
    data_read = 32'h0; p0_req = 1'b0; p0_addr = '0; p0_len = '0;
    p1_req = 1'b0; p1_addr = '0; p1_len = '0; p1_we = 1'b0; p1_wdata = 32'h0; p1_wdqm = 4'h0;
    repeat (3) step();

    chk("rst_strobes", 64'({sdrc_rd_n, sdrc_wr_n}), 64'b11);
    chk("rst_cmd", 64'({sdrc_addr, sdrc_len, sdrc_dqm}), 64'd0);
    chk("rst_data_write", 64'(sdrc_data_write), 64'd0);
    chk("rst_flags", 64'({p0_ack, p1_ack, p0_rvalid, p1_rvalid, p0_done, p1_done, p1_wnext,
                          self_ref, pwr_dn}), 64'd0);

    // Init not done: request must wait.
    rst = 1'b0; p0_req = 1'b1; p0_addr = 21'h000321; p0_len = 7'd0;
    bad = 1'b0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (p0_ack || p1_ack || !sdrc_rd_n) bad = 1'b1;
      step();
    end
    chk("init_wait_quiet", 64'(bad), 64'd0);
    init_done = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (p0_ack) begin got = 1'b1; break; end
      step();
    end
    chk("init_p0_ack", 64'(got), 64'd1);
    if (got) begin
      step();
      p0_req = 1'b0;
      vt = '{port:1'b0, we:1'b0, addr:21'h000321, len:7'd0, dqm:4'h0, busy:0,
             base:32'h0BAD_F00D, exp_beats:1, exp_dqm:4'h0};
      complete_burst(vt, "init_burst");
    end
    p0_req = 1'b0;
    step();

    for (int k = 0; k < 5; k++) run_burst(vecs[k], $sformatf("v%0d", k));

    // Simultaneous requests: p0 first, p1 in the cycle after p0_done.
    p0_req = 1'b1; p0_addr = 21'h000200; p0_len = 7'd1;
    p1_req = 1'b1; p1_addr = 21'h000300; p1_len = 7'd0; p1_we = 1'b0; p1_wdqm = 4'h0;
    #1;
    chk("both_p0_ack", 64'(p0_ack), 64'd1);
    chk("both_p1_noack", 64'(p1_ack), 64'd0);
    step();
    p0_req = 1'b0;
    s1 = m_a1;
    vt = '{port:1'b0, we:1'b0, addr:21'h000200, len:7'd1, dqm:4'h0, busy:0,
           base:32'h2222_0000, exp_beats:2, exp_dqm:4'h0};
    complete_burst(vt, "both_p0");
    chk("both_p1_held_off", 64'(m_a1 - s1), 64'd0);
    #1;
    chk("both_p1_ack_after_done", 64'(p1_ack), 64'd1);
    step();
    p1_req = 1'b0;
    vt = '{port:1'b1, we:1'b0, addr:21'h000300, len:7'd0, dqm:4'h0, busy:0,
           base:32'h3333_0000, exp_beats:1, exp_dqm:4'h0};
    complete_burst(vt, "both_p1");

    // Beat strobes in IDLE are ignored.
    s0 = m_rv0; s1 = m_rv1; sd = m_wn;
    rd_valid = 1'b1; wrd_ack = 1'b1; data_read = 32'hDEAD_BEEF;
    #1;
    chk("idle_wnext", 64'(p1_wnext), 64'd0);
    step();
    rd_valid = 1'b0; wrd_ack = 1'b0;
    step();
    chk("idle_no_rvalid", 64'((m_rv0 - s0) + (m_rv1 - s1)), 64'd0);
    chk("idle_no_wnext", 64'(m_wn - sd), 64'd0);

    // Reset mid-burst: no done, strobes high, recovery afterwards.
    vt = '{port:1'b0, we:1'b0, addr:21'h000040, len:7'd7, dqm:4'h0, busy:0,
           base:32'h4444_0000, exp_beats:8, exp_dqm:4'h0};
    req_and_ack(vt, "abort", got);
    step();
    for (int b = 0; b < 3; b++) begin
      rd_valid = 1'b1; data_read = 32'h4444_0000 + 32'(b);
      step();
    end
    sd = m_d0;
    rst = 1'b1;
    step();
    rd_valid = 1'b0;
    chk("abort_rvalid", 64'(p0_rvalid), 64'd0);
    chk("abort_strobes", 64'({sdrc_rd_n, sdrc_wr_n}), 64'b11);
    rst = 1'b0;
    repeat (4) step();
    chk("abort_no_done", 64'(m_d0 - sd), 64'd0);
    run_burst(vecs[2], "after_abort");

    // Starvation: p0 continuously requesting while p1 waits.
    p0_req = 1'b1; p0_addr = 21'h000500; p0_len = 7'd0;
    p1_req = 1'b1; p1_addr = 21'h000600; p1_len = 7'd0; p1_we = 1'b0; p1_wdqm = 4'h0;
    for (int g = 0; g < 5; g++) begin
      got = 1'b0; which = 1'b0;
      for (int c = 0; c < 10; c++) begin
        #1;
        if (p0_ack || p1_ack) begin got = 1'b1; which = p1_ack; break; end
        step();
      end
      chk($sformatf("guard_grant%0d_seen", g), 64'(got), 64'd1);
      if (!got) break;
`ifdef SDRC_ARB_STARVE_GUARD_EN
      chk($sformatf("guard_grant%0d_port", g), 64'(which), (g == 4) ? 64'd1 : 64'd0);
`else
      chk($sformatf("guard_grant%0d_port", g), 64'(which), 64'd0);
`endif
      step();
      vg = '{port:which, we:1'b0, addr:(which ? 21'h000600 : 21'h000500), len:7'd0, dqm:4'h0,
             busy:0, base:32'h6000_0000 + 32'(g), exp_beats:1, exp_dqm:4'h0};
      complete_burst(vg, $sformatf("guard%0d", g));
    end
    p0_req = 1'b0; p1_req = 1'b0;
    s0 = m_a0; s1 = m_a1;
    repeat (4) step();
    chk("dropped_req_not_served", 64'((m_a0 - s0) + (m_a1 - s1)), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
